// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter that shares the single ALU/register-bank execution path
// between N requesters. It latches the owner's instruction onto the datapath,
// runs the control sequencer's Start/Go handshake and returns a one-cycle Done.
// A sequencer that stalls too long aborts the transaction and sets sticky Err.
module alu_op_arbiter #(
  parameter int N       = 4,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         Req,
  input  logic [N*INSTR_W-1:0] InstrIn,
  output logic [N-1:0]         Grant,
  output logic [N-1:0]         Done,
  output logic                 Err,
  output logic [INSTR_W-1:0]   InstrOut,
  output logic                 CtlStart,
  output logic                 CtlGo,
  input  logic                 CtlReady,
  input  logic                 CtlWen
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [N-1:0]     ONE      = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for a request with the sequencer halted
    S_ISSUE,  // Start held until the sequencer leaves Ready
    S_EXEC,   // waiting for the write-back pulse
    S_SYNC    // Go held until the sequencer halts again
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [N-1:0]       grant_d, done_d;
  logic               err_d, start_d, go_d;
  logic [INSTR_W-1:0] instr_d;

  logic [INSTR_W-1:0] instr_arr [N];
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic               expired;
  logic               abort;

  // Unpack the flat instruction bus into one word per requester.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      instr_arr[i] = InstrIn[i*INSTR_W +: INSTR_W];
    end
  end

  // Round-robin search: first active request after the last served owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_q) + k) % N);
      if (!sel_found && Req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign expired = (cnt_q == CNT_MAX);

  // Next-state and next-output logic for the handshake sequencer.
  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = Grant;
    done_d  = '0;
    err_d   = Err;
    instr_d = InstrOut;
    start_d = CtlStart;
    go_d    = CtlGo;
    abort   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A Done cycle is never also a grant cycle, leaving one idle cycle.
        if (CtlReady && sel_found && (Done == '0)) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          owner_d = sel_idx;
          grant_d = ONE << sel_idx;
          instr_d = instr_arr[sel_idx];
          start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!CtlReady) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (expired) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (CtlWen) begin
          go_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_SYNC;
        end else if (expired) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SYNC: begin
        if (CtlReady) begin
          go_d    = 1'b0;
          grant_d = '0;
          done_d  = ONE << owner_q;
          last_d  = owner_q;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (expired) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Hung sequencer: drop the owner without Done and move priority past it.
    if (abort) begin
      err_d   = 1'b1;
      start_d = 1'b0;
      go_d    = 1'b0;
      grant_d = '0;
      last_d  = owner_q;
      cnt_d   = '0;
      state_d = S_IDLE;
    end
  end

  // State and registered outputs; reset leaves requester 0 with first priority.
  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= LAST_RST;
      owner_q  <= '0;
      Grant    <= '0;
      Done     <= '0;
      Err      <= 1'b0;
      InstrOut <= '0;
      CtlStart <= 1'b0;
      CtlGo    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      Grant    <= grant_d;
      Done     <= done_d;
      Err      <= err_d;
      InstrOut <= instr_d;
      CtlStart <= start_d;
      CtlGo    <= go_d;
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Bench for alu_op_arbiter: a behavioural control-sequencer model answers the
// Start/Go handshake, and a round-robin reference model predicts every owner.
module tb_alu_op_arbiter;

  localparam int N       = 4;
  localparam int INSTR_W = 16;
  localparam int TIMEOUT = 32;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [N-1:0]         Req;
  logic [N*INSTR_W-1:0] InstrIn;
  logic [N-1:0]         Grant;
  logic [N-1:0]         Done;
  logic                 Err;
  logic [INSTR_W-1:0]   InstrOut;
  logic                 CtlStart;
  logic                 CtlGo;
  logic                 CtlReady;
  logic                 CtlWen;

  alu_op_arbiter #(.N(N), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .InstrIn(InstrIn),
    .Grant(Grant), .Done(Done), .Err(Err), .InstrOut(InstrOut),
    .CtlStart(CtlStart), .CtlGo(CtlGo), .CtlReady(CtlReady), .CtlWen(CtlWen)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Sequencer model knobs: latencies in cycles, hang suppresses write-back.
  int lat_start = 2;
  int lat_wen   = 3;
  int lat_go    = 2;
  bit seq_hang  = 1'b0;
  bit seq_stray = 1'b0;
  int sp, sc;

  // Reference model state.
  int model_last;
  bit model_err;

  function automatic int rr_pick(int last, logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [INSTR_W-1:0] slot(logic [N*INSTR_W-1:0] bus, int i);
    return bus[i*INSTR_W +: INSTR_W];
  endfunction

  // Control sequencer model, driven on the falling edge.
  initial begin
    CtlReady = 1'b1;
    CtlWen   = 1'b0;
    sp = 0;
    sc = 0;
    forever begin
      @(negedge CLK);
      CtlWen = 1'b0;
      if (!RST) begin
        sp = 0;
        CtlReady = 1'b1;
      end else if (sp != 0 && Grant == '0) begin
        sp = 0;
        CtlReady = 1'b1;
      end else begin
        case (sp)
          0: if (CtlStart) begin sp = 1; sc = 0; end
          1: begin
            sc++;
            if (seq_stray && sc == 1) CtlWen = 1'b1;
            if (sc >= lat_start) begin CtlReady = 1'b0; sp = 2; end
          end
          2: if (!CtlStart) begin sp = 3; sc = 0; end
          3: begin
            sc++;
            if (!seq_hang && sc >= lat_wen) begin CtlWen = 1'b1; sp = 4; end
          end
          4: if (CtlGo) begin sp = 5; sc = 0; end
          5: begin
            sc++;
            if (sc >= lat_go) begin CtlReady = 1'b1; sp = 0; end
          end
          default: sp = 0;
        endcase
      end
    end
  end

  task automatic wait_grant(output logic [N-1:0] g, output int cyc, output bit to);
    g = '0; cyc = 0; to = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge CLK);
      if (Grant != '0) begin g = Grant; cyc = i; to = 1'b0; break; end
    end
  endtask

  task automatic wait_done(output logic [N-1:0] d, output bit to);
    d = '0; to = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge CLK);
      if (Done != '0) begin d = Done; to = 1'b0; break; end
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0;
    Req = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    model_last = N - 1;
    model_err  = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    Req = '0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({Grant, Done, Err} !== '0) begin
      n_bad++; $display("FAIL reset_ctl: Grant=%b Done=%b Err=%b want all 0", Grant, Done, Err);
    end
    n_cmp++;
    if ({InstrOut, CtlStart, CtlGo} !== '0) begin
      n_bad++; $display("FAIL reset_dp: InstrOut=%h Start=%b Go=%b want 0", InstrOut, CtlStart, CtlGo);
    end
    RST = 1'b1;
    model_last = N - 1;
    model_err  = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (Grant !== '0 || CtlStart !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_req: Grant=%b Start=%b want 0", Grant, CtlStart);
    end
  endtask

  task automatic test_single();
    int start_hi, go_hi, both;
    bit got_done;
    apply_reset();
    lat_start = 2; lat_wen = 3; lat_go = 2;
    InstrIn = {$urandom(), $urandom()};
    InstrIn[1*INSTR_W +: INSTR_W] = 16'hA5C3;
    Req = 4'b0010;
    @(negedge CLK);
    n_cmp++;
    if (Grant !== 4'b0010 || InstrOut !== 16'hA5C3) begin
      n_bad++; $display("FAIL single_grant: Grant=%b InstrOut=%h want 0010/a5c3", Grant, InstrOut);
    end
    Req = '0;
    start_hi = int'(CtlStart); go_hi = int'(CtlGo); both = 0; got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (Done != '0) begin got_done = 1'b1; break; end
      start_hi += int'(CtlStart);
      go_hi    += int'(CtlGo);
      if (CtlStart && CtlGo) both++;
    end
    n_cmp++;
    if (!got_done || Done !== 4'b0010 || Grant !== '0) begin
      n_bad++; $display("FAIL single_done: Done=%b Grant=%b seen=%0b want 0010/0000", Done, Grant, got_done);
    end
    n_cmp++;
    if (start_hi != lat_start + 1 || go_hi != lat_go + 1 || both != 0) begin
      n_bad++; $display("FAIL single_handshake: start_cycles=%0d go_cycles=%0d overlap=%0d want %0d/%0d/0",
                        start_hi, go_hi, both, lat_start + 1, lat_go + 1);
    end
    @(negedge CLK);
    n_cmp++;
    if (Done !== '0) begin
      n_bad++; $display("FAIL single_done_width: Done=%b one cycle later, want 0000", Done);
    end
    model_last = 1;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] g, d;
    int cyc;
    bit to, to2;
    apply_reset();
    Req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g, cyc, to);
      n_cmp++;
      if (to || g !== onehot(exp_order[i])) begin
        n_bad++; $display("FAIL rr_grant[%0d]: Grant=%b want %b", i, g, onehot(exp_order[i]));
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc < 2) begin
          n_bad++; $display("FAIL rr_gap[%0d]: grant %0d cycles after Done, want >= 2", i, cyc);
        end
      end
      if (i == 4) Req = '0;
      wait_done(d, to2);
      n_cmp++;
      if (to2 || d !== onehot(exp_order[i])) begin
        n_bad++; $display("FAIL rr_done[%0d]: Done=%b want %b", i, d, onehot(exp_order[i]));
      end
    end
    model_last = 0;
  endtask

  task automatic test_fairness();
    int exp_order[3] = '{0, 1, 2};
    logic [N-1:0] g, d;
    int cyc;
    bit to, to2;
    apply_reset();
    seq_stray = 1'b1;
    InstrIn = {$urandom(), $urandom()};
    Req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      wait_grant(g, cyc, to);
      n_cmp++;
      if (to || g !== onehot(exp_order[i]) || InstrOut !== slot(InstrIn, exp_order[i])) begin
        n_bad++; $display("FAIL fair_grant[%0d]: Grant=%b InstrOut=%h want %b/%h", i, g, InstrOut,
                          onehot(exp_order[i]), slot(InstrIn, exp_order[i]));
      end
      if (i == 0) Req = 4'b0111;
      if (i == 2) Req = '0;
      wait_done(d, to2);
      n_cmp++;
      if (to2 || d !== onehot(exp_order[i])) begin
        n_bad++; $display("FAIL fair_done[%0d]: Done=%b want %b", i, d, onehot(exp_order[i]));
      end
    end
    seq_stray = 1'b0;
    model_last = 2;
  endtask

  task automatic test_drop_req();
    logic [N-1:0] g, d;
    logic [INSTR_W-1:0] exp_instr;
    int cyc, exp;
    bit to, to2, in_exec;
    InstrIn = {$urandom(), $urandom()};
    Req = 4'b1000;
    exp = rr_pick(model_last, Req);
    exp_instr = slot(InstrIn, exp);
    wait_grant(g, cyc, to);
    n_cmp++;
    if (to || g !== onehot(exp) || InstrOut !== exp_instr) begin
      n_bad++; $display("FAIL drop_grant: Grant=%b InstrOut=%h want %b/%h", g, InstrOut, onehot(exp), exp_instr);
    end
    in_exec = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!CtlStart) begin in_exec = 1'b1; break; end
    end
    Req = '0;
    InstrIn = ~InstrIn;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (!in_exec || InstrOut !== exp_instr || Grant !== onehot(exp)) begin
      n_bad++; $display("FAIL drop_hold: InstrOut=%h Grant=%b exec=%0b want %h/%b", InstrOut, Grant, in_exec,
                        exp_instr, onehot(exp));
    end
    wait_done(d, to2);
    n_cmp++;
    if (to2 || d !== onehot(exp) || InstrOut !== exp_instr) begin
      n_bad++; $display("FAIL drop_done: Done=%b InstrOut=%h want %b/%h", d, InstrOut, onehot(exp), exp_instr);
    end
    model_last = exp;
    repeat (4) @(negedge CLK);
    n_cmp++;
    if (Grant !== '0) begin
      n_bad++; $display("FAIL drop_no_regrant: Grant=%b want 0000", Grant);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] g, d;
    int cyc, exp;
    bit to, to2;
    Req = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      exp = rr_pick(model_last, Req);
      wait_grant(g, cyc, to);
      n_cmp++;
      if (to || g !== onehot(exp) || (i == 1 && cyc < 2)) begin
        n_bad++; $display("FAIL b2b_grant[%0d]: Grant=%b gap=%0d want %b, gap >= 2", i, g, cyc, onehot(exp));
      end
      if (i == 1) Req = '0;
      wait_done(d, to2);
      n_cmp++;
      if (to2 || d !== onehot(exp)) begin
        n_bad++; $display("FAIL b2b_done[%0d]: Done=%b want %b", i, d, onehot(exp));
      end
      model_last = exp;
    end
  endtask

  task automatic test_hang();
    logic [N-1:0] g, d;
    int cyc, exp, exp2, err_k;
    bit to, to2, in_exec, done_seen;
    lat_start = 2; lat_wen = 3; lat_go = 2;
    seq_hang = 1'b1;
    Req = 4'b0011;
    exp = rr_pick(model_last, Req);
    wait_grant(g, cyc, to);
    n_cmp++;
    if (to || g !== onehot(exp)) begin
      n_bad++; $display("FAIL hang_grant: Grant=%b want %b", g, onehot(exp));
    end
    in_exec = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!CtlStart) begin in_exec = 1'b1; break; end
    end
    err_k = -1;
    done_seen = 1'b0;
    for (int k = 1; k <= TIMEOUT + 8; k++) begin
      @(negedge CLK);
      if (Done != '0) done_seen = 1'b1;
      if (Err) begin err_k = k; break; end
    end
    n_cmp++;
    if (!in_exec || err_k != TIMEOUT) begin
      n_bad++; $display("FAIL hang_err_time: Err after %0d cycles in EXEC, want %0d", err_k, TIMEOUT);
    end
    n_cmp++;
    if (Grant !== '0 || CtlStart !== 1'b0 || CtlGo !== 1'b0 || done_seen) begin
      n_bad++; $display("FAIL hang_abort: Grant=%b Start=%b Go=%b done_seen=%0b want 0", Grant, CtlStart, CtlGo,
                        done_seen);
    end
    seq_hang = 1'b0;
    model_last = exp;
    model_err  = 1'b1;
    exp2 = rr_pick(model_last, Req);
    wait_grant(g, cyc, to);
    n_cmp++;
    if (to || g !== onehot(exp2)) begin
      n_bad++; $display("FAIL hang_next_grant: Grant=%b want %b", g, onehot(exp2));
    end
    Req = '0;
    wait_done(d, to2);
    n_cmp++;
    if (to2 || d !== onehot(exp2) || Err !== model_err) begin
      n_bad++; $display("FAIL hang_sticky: Done=%b Err=%b want %b/%b", d, Err, onehot(exp2), model_err);
    end
    model_last = exp2;
  endtask

  task automatic test_reset_sync();
    logic [N-1:0] g, d;
    int cyc, exp;
    bit to, to2, in_sync;
    Req = 4'b0100;
    exp = rr_pick(model_last, Req);
    wait_grant(g, cyc, to);
    n_cmp++;
    if (to || g !== onehot(exp)) begin
      n_bad++; $display("FAIL rst_sync_grant: Grant=%b want %b", g, onehot(exp));
    end
    in_sync = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (CtlGo) begin in_sync = 1'b1; break; end
    end
    #2;
    RST = 1'b0;
    #1;
    n_cmp++;
    if (!in_sync || Grant !== '0 || CtlGo !== 1'b0 || Done !== '0 || Err !== 1'b0) begin
      n_bad++; $display("FAIL rst_sync_clear: Grant=%b Go=%b Done=%b Err=%b sync=%0b want all 0", Grant, CtlGo,
                        Done, Err, in_sync);
    end
    n_cmp++;
    if (CtlStart !== 1'b0 || InstrOut !== '0) begin
      n_bad++; $display("FAIL rst_sync_dp: Start=%b InstrOut=%h want 0", CtlStart, InstrOut);
    end
    model_last = N - 1;
    model_err  = 1'b0;
    repeat (2) @(negedge CLK);
    Req = 4'b1111;
    RST = 1'b1;
    exp = rr_pick(model_last, Req);
    wait_grant(g, cyc, to);
    n_cmp++;
    if (to || g !== onehot(exp)) begin
      n_bad++; $display("FAIL rst_sync_priority: Grant=%b want %b", g, onehot(exp));
    end
    Req = '0;
    wait_done(d, to2);
    n_cmp++;
    if (to2 || d !== onehot(exp)) begin
      n_bad++; $display("FAIL rst_sync_done: Done=%b want %b", d, onehot(exp));
    end
    model_last = exp;
  endtask

  task automatic test_random();
    logic [N-1:0] g, d;
    logic [INSTR_W-1:0] exp_instr;
    int cyc, exp;
    bit to, to2;
    for (int t = 0; t < 40; t++) begin
      lat_start = $urandom_range(1, 4);
      lat_wen   = $urandom_range(1, 4);
      lat_go    = $urandom_range(1, 4);
      Req       = N'($urandom_range(1, (1 << N) - 1));
      InstrIn   = {$urandom(), $urandom()};
      exp       = rr_pick(model_last, Req);
      exp_instr = slot(InstrIn, exp);
      wait_grant(g, cyc, to);
      n_cmp++;
      if (to || g !== onehot(exp) || InstrOut !== exp_instr) begin
        n_bad++; $display("FAIL rand_grant[%0d]: Grant=%b InstrOut=%h want %b/%h", t, g, InstrOut,
                          onehot(exp), exp_instr);
      end
      @(negedge CLK);
      Req     = N'($urandom_range(0, (1 << N) - 1));
      InstrIn = {$urandom(), $urandom()};
      wait_done(d, to2);
      n_cmp++;
      if (to2 || d !== onehot(exp) || InstrOut !== exp_instr) begin
        n_bad++; $display("FAIL rand_done[%0d]: Done=%b InstrOut=%h want %b/%h", t, d, InstrOut,
                          onehot(exp), exp_instr);
      end
      model_last = exp;
      if ($urandom_range(0, 3) == 0) begin
        Req = '0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (Grant !== '0) begin
          n_bad++; $display("FAIL rand_idle[%0d]: Grant=%b want 0000", t, Grant);
        end
      end
    end
    Req = '0;
    n_cmp++;
    if (Err !== model_err) begin
      n_bad++; $display("FAIL rand_err: Err=%b want %b", Err, model_err);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Req     = '0;
    InstrIn = '0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_drop_req();
    test_back_to_back();
    test_hang();
    test_reset_sync();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
